// File: rtl/proto245_bist_if.sv
// FIFO-side bus between proto245_bist and the proto245 system-side FIFOs.
// master = traffic generator/checker, slave = FIFO side.
interface proto245_bist_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] txfifo_data;
  logic              txfifo_wr;
  logic              txfifo_full;
  logic              rxfifo_rd;
  logic [DATA_W-1:0] rxfifo_data;
  logic              rxfifo_valid;
  logic              rxfifo_empty;

  modport master (
    output txfifo_data, txfifo_wr, rxfifo_rd,
    input  txfifo_full, rxfifo_data, rxfifo_valid, rxfifo_empty
  );

  modport slave (
    input  txfifo_data, txfifo_wr, rxfifo_rd,
    output txfifo_full, rxfifo_data, rxfifo_valid, rxfifo_empty
  );
endinterface

// File: rtl/proto245_bist.sv
// Loopback traffic generator (counter / PRBS16) and checker for the proto245 system side.
// Generator and checker share one pattern function so TX and expected RX streams stay identical.
module proto245_bist #(
  parameter int          DATA_W = 8,
  parameter int          LEN_W  = 32,
  parameter int          ERR_W  = 16,
  parameter logic [15:0] SEED   = 16'hACE1
) (
  input  logic                clk,
  input  logic                rstn,
  input  logic                clr,
  input  logic                mode,
  input  logic                tx_en,
  input  logic                rx_en,
  input  logic [LEN_W-1:0]    tx_len,
  input  logic [7:0]          tx_gap,
  proto245_bist_if.master     fifo,
  output logic [LEN_W-1:0]    tx_cnt,
  output logic [LEN_W-1:0]    rx_cnt,
  output logic [ERR_W-1:0]    err_cnt,
  output logic [2*DATA_W-1:0] first_err,
  output logic                tx_done
);

  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
  localparam logic [15:0] WORD_MASK = 16'((17'h1 << DATA_W) - 17'h1);

  // Counter mode only touches the low DATA_W bits so it wraps mod 2^DATA_W.
  function automatic logic [15:0] pat_next(input logic [15:0] s, input logic prbs);
    if (prbs)
      return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
    return (s & ~WORD_MASK) | ((s + 16'h0001) & WORD_MASK);
  endfunction

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_GAP, S_DONE} tx_state_t;

  tx_state_t           state_reg, state_next;
  logic [7:0]          gap_reg, gap_next;
  logic [15:0]         gen_reg, gen_next;
  logic [LEN_W-1:0]    tx_cnt_reg, tx_cnt_next;
  logic                tx_done_reg;
  logic [15:0]         exp_reg, exp_next;
  logic [LEN_W-1:0]    rx_cnt_reg, rx_cnt_next;
  logic [ERR_W-1:0]    err_reg, err_next;
  logic [2*DATA_W-1:0] first_err_reg, first_err_next;
  logic                rd_ok_reg;

  logic                tx_wr;
  logic                tx_exhausted;
  logic [LEN_W-1:0]    tx_cnt_inc;
  logic [DATA_W-1:0]   rx_word;
  logic [DATA_W-1:0]   exp_word;
  logic [15:0]         rx_ext;

  assign tx_exhausted = (tx_len != '0) && (tx_cnt_reg >= tx_len);
  assign tx_wr        = (state_reg == S_RUN) && !fifo.txfifo_full && !tx_exhausted;
  assign tx_cnt_inc   = tx_cnt_reg + LEN_W'(1);

  always_comb begin
    state_next  = state_reg;
    gap_next    = gap_reg;
    gen_next    = gen_reg;
    tx_cnt_next = tx_cnt_reg;
    if (tx_wr) begin
      gen_next    = pat_next(gen_reg, mode);
      tx_cnt_next = tx_cnt_inc;
    end
    case (state_reg)
      S_IDLE: if (tx_en) state_next = S_RUN;
      S_RUN: begin
        if (!tx_en)
          state_next = S_IDLE;
        else if (tx_exhausted)
          state_next = S_DONE;
        else if (tx_wr) begin
          if ((tx_len != '0) && (tx_cnt_inc == tx_len))
            state_next = S_DONE;
          else if (tx_gap != 8'd0) begin
            state_next = S_GAP;
            gap_next   = tx_gap;
          end
        end
      end
      S_GAP: begin
        if (!tx_en)
          state_next = S_IDLE;
        else if (gap_reg <= 8'd1)
          state_next = S_RUN;
        else
          gap_next = gap_reg - 8'd1;
      end
      S_DONE: if (!tx_en) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign rx_word  = fifo.rxfifo_data;
  assign exp_word = exp_reg[DATA_W-1:0];
  assign rx_ext   = 16'(rx_word);

  // Counter mode resynchronises on the received word; PRBS just keeps stepping.
  always_comb begin
    exp_next       = exp_reg;
    rx_cnt_next    = rx_cnt_reg;
    err_next       = err_reg;
    first_err_next = first_err_reg;
    if (fifo.rxfifo_valid) begin
      rx_cnt_next = rx_cnt_reg + LEN_W'(1);
      if (rx_word == exp_word) begin
        exp_next = pat_next(exp_reg, mode);
      end else begin
        if (err_reg != {ERR_W{1'b1}})
          err_next = err_reg + ERR_W'(1);
        if (err_reg == '0)
          first_err_next = {exp_word, rx_word};
        if (mode)
          exp_next = pat_next(exp_reg, 1'b1);
        else
          exp_next = (exp_reg & ~WORD_MASK) | ((rx_ext + 16'h0001) & WORD_MASK);
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_reg     <= S_IDLE;
      gap_reg       <= 8'd0;
      gen_reg       <= SEED_EFF;
      tx_cnt_reg    <= '0;
      tx_done_reg   <= 1'b0;
      exp_reg       <= SEED_EFF;
      rx_cnt_reg    <= '0;
      err_reg       <= '0;
      first_err_reg <= '0;
      rd_ok_reg     <= 1'b0;
    end else if (clr) begin
      state_reg     <= S_IDLE;
      gap_reg       <= 8'd0;
      gen_reg       <= SEED_EFF;
      tx_cnt_reg    <= '0;
      tx_done_reg   <= 1'b0;
      exp_reg       <= SEED_EFF;
      rx_cnt_reg    <= '0;
      err_reg       <= '0;
      first_err_reg <= '0;
      rd_ok_reg     <= 1'b1;
    end else begin
      state_reg     <= state_next;
      gap_reg       <= gap_next;
      gen_reg       <= gen_next;
      tx_cnt_reg    <= tx_cnt_next;
      tx_done_reg   <= (state_next == S_DONE);
      exp_reg       <= exp_next;
      rx_cnt_reg    <= rx_cnt_next;
      err_reg       <= err_next;
      first_err_reg <= first_err_next;
      rd_ok_reg     <= 1'b1;
    end
  end

  // rd_ok_reg keeps the read strobe low throughout reset regardless of rx_en.
  assign fifo.txfifo_data = gen_reg[DATA_W-1:0];
  assign fifo.txfifo_wr   = tx_wr;
  assign fifo.rxfifo_rd   = rd_ok_reg & rx_en & ~fifo.rxfifo_empty;

  assign tx_cnt    = tx_cnt_reg;
  assign rx_cnt    = rx_cnt_reg;
  assign err_cnt   = err_reg;
  assign first_err = first_err_reg;
  assign tx_done   = tx_done_reg;

endmodule

// File: tb/tb_proto245_bist.sv
// Directed bench: instance A (SEED 0x10) for counter/gap/clr/error/reset tests,
// instance B (default seed) for a PRBS loopback through a queue-based FIFO model.
module tb_proto245_bist;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- instance A ----------------
  logic        a_clr = 0, a_mode = 0, a_tx_en = 0, a_rx_en = 0;
  logic [31:0] a_tx_len = 0;
  logic [7:0]  a_tx_gap = 0;
  logic        a_full = 0, a_valid = 0, a_empty = 1;
  logic [7:0]  a_rdata = 0;
  logic [31:0] a_tx_cnt, a_rx_cnt;
  logic [15:0] a_err, a_first;
  logic        a_done;

  proto245_bist_if #(.DATA_W(8)) bus_a ();
  assign bus_a.txfifo_full  = a_full;
  assign bus_a.rxfifo_data  = a_rdata;
  assign bus_a.rxfifo_valid = a_valid;
  assign bus_a.rxfifo_empty = a_empty;

  proto245_bist #(.DATA_W(8), .LEN_W(32), .ERR_W(16), .SEED(16'h0010)) u_a (
    .clk(clk), .rstn(rstn), .clr(a_clr), .mode(a_mode), .tx_en(a_tx_en), .rx_en(a_rx_en),
    .tx_len(a_tx_len), .tx_gap(a_tx_gap), .fifo(bus_a),
    .tx_cnt(a_tx_cnt), .rx_cnt(a_rx_cnt), .err_cnt(a_err), .first_err(a_first), .tx_done(a_done)
  );

  // ---------------- instance B (loopback) ----------------
  logic        b_clr = 0, b_mode = 1, b_tx_en = 0, b_rx_en = 0;
  logic [31:0] b_tx_len = 32'd1000;
  logic [7:0]  b_tx_gap = 0;
  logic        b_valid = 0, b_empty = 1;
  logic [7:0]  b_rdata = 0;
  logic [31:0] b_tx_cnt, b_rx_cnt;
  logic [15:0] b_err, b_first;
  logic        b_done;
  logic [7:0]  b_q[$];
  int          b_pushed = 0;
  logic [7:0]  b_second = 0;

  proto245_bist_if #(.DATA_W(8)) bus_b ();
  assign bus_b.txfifo_full  = 1'b0;
  assign bus_b.rxfifo_data  = b_rdata;
  assign bus_b.rxfifo_valid = b_valid;
  assign bus_b.rxfifo_empty = b_empty;

  proto245_bist #(.DATA_W(8), .LEN_W(32), .ERR_W(16)) u_b (
    .clk(clk), .rstn(rstn), .clr(b_clr), .mode(b_mode), .tx_en(b_tx_en), .rx_en(b_rx_en),
    .tx_len(b_tx_len), .tx_gap(b_tx_gap), .fifo(bus_b),
    .tx_cnt(b_tx_cnt), .rx_cnt(b_rx_cnt), .err_cnt(b_err), .first_err(b_first), .tx_done(b_done)
  );

  // FIFO model works on the falling edge, where the DUT strobes are settled.
  always @(negedge clk) begin
    if (!rstn) begin
      b_q.delete();
      b_valid <= 1'b0;
      b_empty <= 1'b1;
    end else begin
      if (bus_b.txfifo_wr) begin
        b_q.push_back(bus_b.txfifo_data);
        if (b_pushed == 1) b_second <= bus_b.txfifo_data;
        b_pushed <= b_pushed + 1;
      end
      if (bus_b.rxfifo_rd && b_q.size() > 0) begin
        b_rdata <= b_q.pop_front();
        b_valid <= 1'b1;
      end else begin
        b_valid <= 1'b0;
      end
      b_empty <= (b_q.size() == 0);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clr_a();
    a_clr = 1'b1;
    tick();
    a_clr = 1'b0;
  endtask

  task automatic rx_word(input logic [7:0] d);
    a_valid = 1'b1;
    a_rdata = d;
    tick();
    a_valid = 1'b0;
  endtask

  int          nwr;
  int          full_wr;
  int          wr_c[4];
  logic [7:0]  wr_d[4];

  initial begin
    // reset values
    tick();
    tick();
    check("rst_wr", bus_a.txfifo_wr, 0);
    check("rst_rd", bus_a.rxfifo_rd, 0);
    check("rst_data", bus_a.txfifo_data, 8'h10);
    check("rst_tx_cnt", a_tx_cnt, 0);
    check("rst_rx_cnt", a_rx_cnt, 0);
    check("rst_err", a_err, 0);
    check("rst_first", a_first, 0);
    check("rst_done", a_done, 0);
    rstn = 1'b1;
    tick();
    $display("reset: done");

    // counter burst, len 5, no gap
    a_tx_len = 5;
    a_tx_gap = 0;
    a_tx_en  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check($sformatf("burst_wr%0d", i), bus_a.txfifo_wr, 1);
      check($sformatf("burst_data%0d", i), bus_a.txfifo_data, 8'h10 + i);
      $display("burst: word %0d data=%0h", i, bus_a.txfifo_data);
    end
    tick();
    check("burst_cnt", a_tx_cnt, 5);
    check("burst_done", a_done, 1);
    check("burst_wr_stop", bus_a.txfifo_wr, 0);
    a_tx_en = 1'b0;
    tick();
    check("done_release", a_done, 0);

    // clr then gapped run with a full window
    clr_a();
    check("clr_tx_cnt", a_tx_cnt, 0);
    check("clr_data", bus_a.txfifo_data, 8'h10);
    a_tx_len = 4;
    a_tx_gap = 3;
    a_tx_en  = 1'b1;
    nwr = 0;
    full_wr = 0;
    for (int c = 1; c <= 18; c++) begin
      tick();
      a_full = (c >= 10 && c < 16);
      #1;
      if (bus_a.txfifo_wr) begin
        if (a_full) full_wr++;
        if (nwr < 4) begin
          wr_c[nwr] = c;
          wr_d[nwr] = bus_a.txfifo_data;
        end
        nwr++;
        $display("gap: write cycle %0d data=%0h", c, bus_a.txfifo_data);
      end
      if (c == 14) check("full_hold_data", bus_a.txfifo_data, 8'h13);
    end
    a_full = 1'b0;
    check("gap_nwr", nwr, 4);
    check("gap_full_wr", full_wr, 0);
    check("gap_c0", wr_c[0], 1);
    check("gap_c1", wr_c[1], 5);
    check("gap_c2", wr_c[2], 9);
    check("gap_c3", wr_c[3], 16);
    for (int i = 0; i < 4; i++) check($sformatf("gap_d%0d", i), wr_d[i], 8'h10 + i);
    check("gap_cnt", a_tx_cnt, 4);
    check("gap_done", a_done, 1);
    a_tx_en = 1'b0;
    tick();

    // pause / resume
    clr_a();
    a_tx_len = 0;
    a_tx_gap = 0;
    a_tx_en  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("pause_d%0d", i), bus_a.txfifo_data, 8'h10 + i);
    end
    a_tx_en = 1'b0;
    tick();
    check("pause_wr", bus_a.txfifo_wr, 0);
    check("pause_cnt", a_tx_cnt, 3);
    a_tx_en = 1'b1;
    tick();
    check("resume_wr", bus_a.txfifo_wr, 1);
    check("resume_data", bus_a.txfifo_data, 8'h13);
    $display("pause: resumed data=%0h", bus_a.txfifo_data);
    a_tx_en = 1'b0;
    tick();

    // counter-mode checker with injected error (rx_en low: valid still checked)
    clr_a();
    for (int i = 0; i < 16; i++) rx_word(8'h10 + 8'(i));
    check("rx_cnt16", a_rx_cnt, 16);
    check("rx_err0", a_err, 0);
    rx_word(8'h33);
    check("inj_err", a_err, 1);
    check("inj_first", a_first, 16'h2033);
    rx_word(8'h34);
    check("resync_err", a_err, 1);
    rx_word(8'h99);
    check("second_err", a_err, 2);
    check("second_first", a_first, 16'h2033);
    check("rx_cnt19", a_rx_cnt, 19);
    $display("rx: cnt=%0d err=%0d first=%0h", a_rx_cnt, a_err, a_first);
    a_rx_en = 1'b1;
    a_empty = 1'b0;
    #1;
    check("rd_on", bus_a.rxfifo_rd, 1);
    a_empty = 1'b1;
    #1;
    check("rd_empty", bus_a.rxfifo_rd, 0);
    a_rx_en = 1'b0;

    // PRBS loopback on instance B
    check("prbs_seed", bus_b.txfifo_data, 8'hE1);
    b_tx_en = 1'b1;
    b_rx_en = 1'b1;
    for (int k = 0; k < 3000 && b_rx_cnt != 32'd1000; k++) tick();
    tick();
    check("loop_rx_cnt", b_rx_cnt, 1000);
    check("loop_err", b_err, 0);
    check("loop_tx_cnt", b_tx_cnt, 1000);
    check("loop_done", b_done, 1);
    check("prbs_second", b_second, 8'hC3);
    $display("loopback: tx=%0d rx=%0d err=%0d", b_tx_cnt, b_rx_cnt, b_err);
    b_tx_en = 1'b0;
    b_rx_en = 1'b0;

    // asynchronous reset mid-burst
    a_tx_len = 0;
    a_tx_en  = 1'b1;
    a_rx_en  = 1'b1;
    a_empty  = 1'b0;
    tick();
    tick();
    tick();
    check("pre_rst_wr", bus_a.txfifo_wr, 1);
    check("pre_rst_rd", bus_a.rxfifo_rd, 1);
    #2 rstn = 1'b0;
    #1;
    check("arst_wr", bus_a.txfifo_wr, 0);
    check("arst_rd", bus_a.rxfifo_rd, 0);
    check("arst_data", bus_a.txfifo_data, 8'h10);
    check("arst_tx_cnt", a_tx_cnt, 0);
    check("arst_rx_cnt", a_rx_cnt, 0);
    check("arst_err", a_err, 0);
    check("arst_first", a_first, 0);
    $display("async reset: applied");
    a_tx_en = 1'b0;
    a_rx_en = 1'b0;
    tick();
    rstn = 1'b1;
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/proto245_bist.md
# proto245_bist

Synthesizable traffic generator and checker for the system side of `proto245`. It drives the TX FIFO with a configurable counter or PRBS pattern, with optional length and inter-word gap. It reads the RX FIFO and checks it against the same pattern, keeping word and error counters. It is used for on-board loopback and throughput tests with the host, and works with any `DATA_W` up to 16.

## Interface
- `DATA_W`, 8: FIFO word width, 1..16.
- `LEN_W`, 32: width of length and word counters.
- `ERR_W`, 16: width of the error counter, which saturates.
- `SEED`, 16'hACE1: pattern seed. A zero seed is replaced by 16'hACE1.
- `clk` in 1: system clock, the same clock as `proto245` `clk`.
- `rstn` in 1: asynchronous active-low reset.
- `clr` in 1: synchronous clear of counters, generator and checker.
- `mode` in 1: 0 = counter pattern, 1 = PRBS16 pattern.
- `tx_en` in 1: level enable for the generator.
- `rx_en` in 1: level enable for the checker.
- `tx_len` in LEN_W: number of words to send; 0 = unlimited.
- `tx_gap` in 8: idle cycles inserted after each written word.
- `txfifo_data` out DATA_W: data to `proto245`.
- `txfifo_wr` out 1: write strobe.
- `txfifo_full` in 1: TX FIFO full.
- `rxfifo_rd` out 1: read strobe.
- `rxfifo_data` in DATA_W: read data.
- `rxfifo_valid` in 1: `rxfifo_data` is valid this cycle.
- `rxfifo_empty` in 1: RX FIFO empty.
- `tx_cnt` out LEN_W: words written.
- `rx_cnt` out LEN_W: words checked.
- `err_cnt` out ERR_W: mismatches, saturating.
- `first_err` out 2*DATA_W: {expected, received} for the first mismatch.
- `tx_done` out 1: generator is in DONE.

## Operation
**Pattern generators**
- There are two identical generators, gen (TX) and exp (RX).
- Counter mode:
  - State starts at `SEED[DATA_W-1:0]`.
  - State advances by +1, wrapping mod 2^DATA_W.
- PRBS mode:
  - 16-bit Fibonacci LFSR, polynomial x^16+x^14+x^13+x^11+1.
  - Shift left; the feedback bit enters at bit 0.
  - The output word is `state[DATA_W-1:0]`.
- A generator advances only when its word is consumed.
- `mode` must only change while the block is idle or together with `clr`. Changing it at any other time gives undefined data, but no lockup.

**TX state machine: IDLE, RUN, GAP, DONE**
- IDLE → RUN when `tx_en` = 1.
- In RUN, `txfifo_wr = ~txfifo_full`.
  - On a write: gen advances and `tx_cnt` increments.
  - If `tx_len` ≠ 0 and the new `tx_cnt` == `tx_len`, go to DONE.
  - Otherwise, if `tx_gap` ≠ 0, go to GAP and load the gap counter with `tx_gap`.
  - Otherwise stay in RUN, so back-to-back writes are possible.
- GAP decrements its counter each cycle and returns to RUN when the counter reaches 1.
- RUN or GAP with `tx_en` = 0 → IDLE. The generator state and `tx_cnt` are kept, so re-enabling resumes the sequence.
- DONE → IDLE when `tx_en` = 0.
- Entering RUN with `tx_len` ≠ 0 and `tx_cnt` ≥ `tx_len` goes straight to DONE without writing.

**RX checker**
- `rxfifo_rd = rx_en & ~rxfifo_empty`.
- Every cycle with `rxfifo_valid` = 1 is checked, independent of read latency and of `rx_en`, so data already in flight is still checked.
- On each checked word, `rx_cnt` increments and the received word is compared with exp.
- Mismatch in counter mode:
  - `err_cnt` increments (saturating).
  - exp resynchronises to `rxfifo_data` + 1.
- Mismatch in PRBS mode:
  - `err_cnt` increments (saturating).
  - exp advances normally.
- `first_err` is captured only when `err_cnt` goes from 0 to 1.

**clr**
- In the cycle after `clr`:
  - both generators are reseeded;
  - all counters and `first_err` are 0;
  - the TX FSM is in IDLE.
- `clr` has priority over all other events in the same cycle.

## Timing
- Reset values (`rstn` low, asynchronous):
  - `txfifo_wr` = 0, `rxfifo_rd` = 0;
  - `txfifo_data` = `SEED[DATA_W-1:0]`;
  - `tx_cnt`, `rx_cnt`, `err_cnt`, `first_err` = 0;
  - `tx_done` = 0;
  - FSM in IDLE.
- `txfifo_wr` and `rxfifo_rd` are combinational from registered state and the FIFO flags. A write is never issued while `txfifo_full` = 1 in the same cycle, and a read never while `rxfifo_empty` = 1.
- `txfifo_data` is the registered gen output and is stable while `txfifo_wr` is waiting on full.
- `tx_en` to first write: 1 cycle (IDLE→RUN edge, then write in RUN if not full).
- Throughput with `tx_gap` = g: one word per g+1 cycles.
- Counters and `err_cnt` update one cycle after the triggering event.
- `tx_done` is registered and asserts in the cycle after the last write.
- `err_cnt` saturates at 2^ERR_W−1. `tx_cnt` and `rx_cnt` wrap mod 2^LEN_W.

## Test plan
- Counter mode, `SEED` = 0x10, `tx_len` = 5, `tx_gap` = 0, FIFO never full:
  - writes 0x10..0x14 in 5 consecutive cycles;
  - `tx_cnt` = 5, `tx_done` = 1 one cycle later.
- `tx_gap` = 3, `tx_len` = 4:
  - writes occur exactly 4 cycles apart;
  - `txfifo_full` held for 6 cycles mid-run → no write during full, data held, sequence unbroken.
- Loopback of TX into RX through a model FIFO, PRBS mode, 1000 words:
  - `rx_cnt` = 1000, `err_cnt` = 0.
  - The first PRBS word after 0xACE1 is 0x59C3; check the low DATA_W bits.
- Counter mode, inject 0x33 where 0x20 is expected:
  - `err_cnt` = 1, `first_err` = {0x20, 0x33};
  - next expected word is 0x34, so a following 0x34 causes no error;
  - a second mismatch leaves `first_err` unchanged.
- `tx_en` dropped mid-run after 3 words, re-raised → sequence resumes at word 4 with no duplicates.
- `clr` pulse → counters 0, next write is `SEED`.
- `rstn` asserted mid-burst → outputs take their reset values asynchronously, before the next clock edge.
